// File: rtl/clock_divider_hb.sv
`timescale 1ns/1ps
// clock_divider_hb: enable-gated divide-by-(2*THRESHOLD) clock with ON_TIME heartbeat; optional tick output under CLOCKDIVIDERHB_TICK_EN.
// Latency: every output is a flop that updates on the enabled clk edge; reset clears them asynchronously.
// Backpressure: none; enable low freezes count/dividedClk and forces beat (and tick) low until re-enabled.
module clock_divider_hb #(
    parameter int THRESHOLD = 50_000,
    parameter int ON_TIME   = 20_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic dividedClk,
    output logic beat
`ifdef CLOCKDIVIDERHB_TICK_EN
    ,
    output logic tick
`endif
);

    localparam int CW = (THRESHOLD > 1) ? $clog2(THRESHOLD) : 1;
    localparam logic [CW-1:0] LAST = CW'(THRESHOLD - 1);
    // ON_TIME beyond the window saturates, so beat simply stays high while enabled
    localparam logic [31:0] ON_EFF = (ON_TIME > THRESHOLD) ? 32'(THRESHOLD) :
                                     (ON_TIME < 0)         ? 32'd0 : 32'(ON_TIME);

    if (THRESHOLD < 1 || ON_TIME < 0) begin : g_param_err
        $fatal(1, "clock_divider_hb: THRESHOLD must be >= 1 and ON_TIME >= 0");
    end

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [31:0]   count_next_ext;
    logic          wrap;

    assign wrap           = (count == LAST);
    assign count_next     = wrap ? '0 : count + CW'(1);
    assign count_next_ext = 32'(count_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            dividedClk <= 1'b0;
            beat       <= 1'b0;
        end else if (enable) begin
            count <= count_next;
            if (wrap)
                dividedClk <= ~dividedClk;
            beat <= (count_next_ext < ON_EFF);
        end else begin
            beat <= 1'b0;
        end
    end

`ifdef CLOCKDIVIDERHB_TICK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick <= 1'b0;
        else
            tick <= enable & wrap;
    end
`endif

endmodule

// File: tb/tb_clock_divider_hb.sv
`timescale 1ns/1ps
// Directed bench for clock_divider_hb: default-parameter timing plus small-parameter vector table and corner sequences.
module tb_clock_divider_hb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d, en_d, div_d, beat_d;
    logic rst5, en5, div5, beat5;
    logic rst1, en1, div1, beat1;
    logic rstz, enz, divz, beatz;
`ifdef CLOCKDIVIDERHB_TICK_EN
    logic tick_d, tick5, tick1, tickz;
`endif

    int n_vec = 0;
    int n_bad = 0;

    clock_divider_hb u_d (.clk(clk), .reset(rst_d), .enable(en_d), .dividedClk(div_d), .beat(beat_d)
`ifdef CLOCKDIVIDERHB_TICK_EN
        , .tick(tick_d)
`endif
    );
    clock_divider_hb #(.THRESHOLD(5), .ON_TIME(2)) u5 (.clk(clk), .reset(rst5), .enable(en5),
        .dividedClk(div5), .beat(beat5)
`ifdef CLOCKDIVIDERHB_TICK_EN
        , .tick(tick5)
`endif
    );
    clock_divider_hb #(.THRESHOLD(1), .ON_TIME(1)) u1 (.clk(clk), .reset(rst1), .enable(en1),
        .dividedClk(div1), .beat(beat1)
`ifdef CLOCKDIVIDERHB_TICK_EN
        , .tick(tick1)
`endif
    );
    clock_divider_hb #(.THRESHOLD(5), .ON_TIME(0)) uz (.clk(clk), .reset(rstz), .enable(enz),
        .dividedClk(divz), .beat(beatz)
`ifdef CLOCKDIVIDERHB_TICK_EN
        , .tick(tickz)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic       div;
        logic       beat;
        logic [2:0] cnt;
        logic       tk;
    } vec_t;

    vec_t vt[27];

    initial begin
        rst_d = 1'b1; en_d = 1'b0;
        rst5  = 1'b1; en5  = 1'b0;
        rst1  = 1'b1; en1  = 1'b1;
        rstz  = 1'b1; enz  = 1'b1;

        // THRESHOLD=5, ON_TIME=2: {rst, en, dividedClk, beat, count, tick} after each edge
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0};
        for (int i = 10; i < 17; i++)
            vt[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0};
        vt[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0};
        vt[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1};
        vt[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0};
        vt[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0};
        vt[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0};
        vt[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0};
        vt[23] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1};
        vt[24] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
        vt[25] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0};
        vt[26] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0};

        fork
            begin : default_params
                #50;
                check("dflt_reset_t50", {div_d, beat_d}, 2'b00);
                #50 en_d = 1'b1;
                #10;
                check("dflt_reset_en_t110", {div_d, beat_d}, 2'b00);
                #10 rst_d = 1'b0;
                for (int k = 1; k <= 50001; k++) begin
                    @(posedge clk); #1;
                    if (k == 1)     check("dflt_first_edge", {div_d, beat_d}, 2'b01);
                    if (k == 19999) check("dflt_beat_last_hi", {div_d, beat_d}, 2'b01);
                    if (k == 20000) check("dflt_beat_fall", {div_d, beat_d}, 2'b00);
                    if (k == 49999) check("dflt_pre_toggle", {div_d, beat_d}, 2'b00);
                    if (k == 50000) begin
                        check("dflt_toggle", {div_d, beat_d}, 2'b11);
                        check("dflt_rise_time", 32'($time), 32'd500116);
`ifdef CLOCKDIVIDERHB_TICK_EN
                        check("dflt_tick", {31'd0, tick_d}, 32'd1);
`endif
                    end
                    if (k == 50001) begin
                        check("dflt_post_toggle", {div_d, beat_d}, 2'b11);
`ifdef CLOCKDIVIDERHB_TICK_EN
                        check("dflt_tick_drop", {31'd0, tick_d}, 32'd0);
`endif
                    end
                end
            end
            begin : small_params
                @(posedge clk); #1;
                for (int i = 0; i < 27; i++) begin
                    rst5 = vt[i].rst;
                    en5  = vt[i].en;
                    @(posedge clk); #1;
                    check($sformatf("t5_vec%0d", i), {div5, beat5, u5.count},
                          {vt[i].div, vt[i].beat, vt[i].cnt});
`ifdef CLOCKDIVIDERHB_TICK_EN
                    check($sformatf("t5_tick%0d", i), {31'd0, tick5}, {31'd0, vt[i].tk});
`endif
                end
                // asynchronous reset between edges with count=3, dividedClk=1
                #2 rst5 = 1'b1;
                #1;
                check("t5_async_rst", {div5, beat5, u5.count}, 5'd0);
                @(posedge clk); #1;
                check("t5_rst_hold_en", {div5, beat5, u5.count}, 5'd0);
                rst5 = 1'b0;
                @(posedge clk); #1;
                check("t5_after_rst", {div5, beat5, u5.count}, {1'b0, 1'b1, 3'd1});

                // THRESHOLD=1, ON_TIME=1
                check("t1_reset", {div1, beat1}, 2'b00);
                rst1 = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    @(posedge clk); #1;
                    check($sformatf("t1_edge%0d", k), {div1, beat1, u1.count},
                          {(k % 2 == 1) ? 1'b1 : 1'b0, 1'b1, 1'b0});
`ifdef CLOCKDIVIDERHB_TICK_EN
                    check($sformatf("t1_tick%0d", k), {31'd0, tick1}, 32'd1);
`endif
                end
                en1 = 1'b0;
                @(posedge clk); #1;
                check("t1_disabled", {div1, beat1}, 2'b00);
                en1 = 1'b1;
                @(posedge clk); #1;
                check("t1_reenabled", {div1, beat1}, 2'b11);

                // THRESHOLD=5, ON_TIME=0
                rstz = 1'b0;
                for (int k = 1; k <= 10; k++) begin
                    @(posedge clk); #1;
                    check($sformatf("t0_edge%0d", k), {divz, beatz},
                          {(k >= 5 && k < 10) ? 1'b1 : 1'b0, 1'b0});
                end
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_divider_hb.md
Name: clock_divider_hb

Overview:
- Enable-gated programmable clock divider with a heartbeat output, clocked from the system clock (100 MHz in the target design).
- Counts THRESHOLD enabled clk cycles per half-period of dividedClk, so the divided clock period is 2*THRESHOLD clk cycles.
- beat is a registered strobe that is high for ON_TIME of every THRESHOLD enabled cycles; it drives a status LED or watchdog heartbeat.
- dividedClk is a registered logic signal, not a clock-tree net.

Parameters:
- THRESHOLD, 50_000, enabled clk cycles per dividedClk half-period; legal range >= 1.
- ON_TIME, 20_000, beat high cycles per THRESHOLD window; legal range 0..THRESHOLD, and values above THRESHOLD behave as THRESHOLD.
- CW, derived localparam = max(1, $clog2(THRESHOLD)), counter width; not user-overridable.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  count enable, sampled on the rising edge of clk.
- dividedClk  output  1  divided clock, period 2*THRESHOLD enabled cycles, 50% duty.
- beat  output  1  heartbeat, high ON_TIME of every THRESHOLD enabled cycles.

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Reset: takes effect immediately, with no clk edge needed, including mid-count.
  - count = 0, dividedClk = 0, beat = 0.
  - All three hold these values while reset = 1, regardless of enable.
- Enabled cycle (reset = 0, enable = 1, rising clk):
  - If count == THRESHOLD-1: count <= 0 and dividedClk <= ~dividedClk.
  - Otherwise: count <= count + 1, and dividedClk holds.
  - beat <= (count_next < ON_TIME), where count_next is the value count is loaded with on this edge. beat therefore always equals (count < ON_TIME) after any enabled edge.
- Disabled cycle (reset = 0, enable = 0, rising clk):
  - count and dividedClk hold their values.
  - beat <= 0.
  - On re-enable, counting resumes from the held count; there is no restart.
- Alignment:
  - On the edge where dividedClk toggles, count becomes 0 and beat rises in the same cycle, provided ON_TIME >= 1.
  - beat then stays high for ON_TIME consecutive enabled cycles.
  - A beat window starts at every dividedClk edge, rising and falling.
- First enabled edge after reset: count = 1, beat = (1 < ON_TIME), dividedClk = 0. Exception: THRESHOLD = 1, where dividedClk = 1 and count stays 0.
- Boundaries:
  - THRESHOLD = 1: dividedClk toggles on every enabled edge (clk/2); beat = 1 continuously if ON_TIME >= 1.
  - ON_TIME = 0: beat is constantly 0.
  - ON_TIME >= THRESHOLD: beat is 1 on every enabled cycle and 0 only when disabled or in reset.
  - count never exceeds THRESHOLD-1, so no wrap beyond the terminal value.
- Parameter checking: an elaboration-time check raises a fatal error when THRESHOLD < 1 or ON_TIME < 0.
- Timing: all outputs come directly from flops, with no combinational path from inputs to outputs.

Optional Feature:
- Macro: CLOCKDIVIDERHB_TICK_EN.
- When defined:
  - Adds an output port tick, 1 bit.
  - tick is registered and high for exactly one clk cycle on each enabled edge where count wraps from THRESHOLD-1 to 0, coincident with the dividedClk toggle.
  - tick is 0 in reset and while enable = 0.
- When undefined: port tick and its logic are absent. All other behaviour is identical in both builds.

Test Plan:
- Reset hold with default parameters: reset = 1 and enable = 0 from t = 0, enable = 1 at 100 ns, reset = 0 at 120 ns.
  - Required: dividedClk = 0 and beat = 0 until 120 ns.
  - Required: first dividedClk rise at 120 ns + 50_000 cycles (500 µs), then toggles every 500 µs.
  - Required: beat high 200 µs of each 500 µs window.
- Default-parameter beat timing, same stimulus: beat rises on the enabled edge one cycle after reset release, then falls 20_000 cycles (200 µs) after each window start.
- Small-parameter duty check, THRESHOLD = 5, ON_TIME = 2, enable held at 1:
  - Required: dividedClk period 10 cycles, duty 5/5.
  - Required: beat pattern 1,1,0,0,0 repeating, aligned with each dividedClk edge.
- Enable freeze, THRESHOLD = 5, ON_TIME = 2: deassert enable at count = 3 for 7 cycles.
  - Required: dividedClk frozen and beat = 0 from the next edge.
  - Required: after re-enable, the toggle occurs 2 enabled edges later.
- Asynchronous reset mid-operation, THRESHOLD = 5: pulse reset between clk edges while count = 3 and dividedClk = 1.
  - Required: dividedClk, beat and count go to 0 immediately, before the next clk edge.
- Corner parameters:
  - THRESHOLD = 1, ON_TIME = 1: dividedClk = clk/2 and beat = 1 whenever enabled.
  - ON_TIME = 0: beat stays 0.
  - With CLOCKDIVIDERHB_TICK_EN defined: tick is a one-cycle pulse at every dividedClk edge.
